apb_uart_bridge: RTL and testbench



---
 rtl/apb_uart_bridge_pkg.sv | 36 +++
 rtl/apb_uart_addr_decode.sv | 36 +++
 rtl/apb_uart_bridge.sv | 188 ++++++++++++++++++
 tb/tb_apb_uart_bridge.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_uart_bridge_pkg.sv
// apb_uart_bridge_pkg
// Shared definitions for the APB-to-UART-core bridge: the register address
// map, the bridge FSM state encoding and the request kinds produced by the
// address decoder.
package apb_uart_bridge_pkg;

  // Register map. Values are kept 32 bits wide and compared against a
  // zero-extended copy of the bus address.
  localparam logic [31:0] ADDR_BAUD   = 32'h00;
  localparam logic [31:0] ADDR_FRAME  = 32'h04;
  localparam logic [31:0] ADDR_PARITY = 32'h08;
  localparam logic [31:0] ADDR_SBITS  = 32'h0C;
  localparam logic [31:0] ADDR_TXDATA = 32'h10;
  localparam logic [31:0] ADDR_RXDATA = 32'h14;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  typedef enum logic [2:0] {
    CFG_WR,
    CFG_RD,
    TX,
    RX,
    ILLEGAL
  } req_kind_t;

  // The four configuration registers are the only read/write locations.
  function automatic logic isConfigAddr(input logic [31:0] addr);
    return (addr == ADDR_BAUD) || (addr == ADDR_FRAME) ||
           (addr == ADDR_PARITY) || (addr == ADDR_SBITS);
  endfunction

endpackage

// File: rtl/apb_uart_addr_decode.sv
// apb_uart_addr_decode
// Purely combinational classifier that turns a bus address plus direction
// into the kind of request the UART core should see.
// Ports:
//   i_addr   - latched or live APB address
//   i_write  - 1 for a write access, 0 for a read
//   o_kind   - CFG_WR / CFG_RD / TX / RX, or ILLEGAL for anything the
//              core cannot service (unmapped, TXDATA read, RXDATA write)
module apb_uart_addr_decode
  import apb_uart_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_write,
  output req_kind_t             o_kind
);

  logic [31:0] w_addr;

  assign w_addr = 32'(i_addr);

  // Config registers accept both directions; TXDATA only writes and
  // RXDATA only reads. Everything else falls through to ILLEGAL.
  always_comb begin
    o_kind = ILLEGAL;
    if (isConfigAddr(w_addr)) begin
      o_kind = i_write ? CFG_WR : CFG_RD;
    end else if ((w_addr == ADDR_TXDATA) && i_write) begin
      o_kind = TX;
    end else if ((w_addr == ADDR_RXDATA) && !i_write) begin
      o_kind = RX;
    end
  end

endmodule

// File: rtl/apb_uart_bridge.sv
// apb_uart_bridge
// APB3 slave front-end for the UART core. A setup phase is latched and
// decoded; legal accesses raise one request strobe toward the core until
// the core answers with ready, illegal accesses are answered at once with
// PSLVERR. The response (PRDATA/PREADY/PSLVERR) is registered and lasts
// exactly one cycle.
// Optional feature: define APB_UART_BRIDGE_TIMEOUT_EN to bound the wait for
// ready to TIMEOUT_CYCLES cycles; a timed-out request ends with PSLVERR=1.
// Ports:
//   PCLK, PRESET                     - clock, async active-high reset
//   PSEL, PENABLE, PWRITE, PADDR,
//   PWDATA, PRDATA, PREADY, PSLVERR  - APB3 slave interface
//   config_address, write_data_in    - latched address/data to the core
//   TX_detect, RX_detect,
//   config_write_detect,
//   config_read_detect               - one-hot request strobes to the core
//   read_data, ready, error          - core response
module apb_uart_bridge
  import apb_uart_bridge_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [ADDR_WIDTH-1:0] config_address,
  output logic [DATA_WIDTH-1:0] write_data_in,
  output logic                  TX_detect,
  output logic                  RX_detect,
  output logic                  config_write_detect,
  output logic                  config_read_detect,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  ready,
  input  logic                  error
);

  state_t                r_state;
  state_t                w_nextState;
  req_kind_t             w_decKind;
  req_kind_t             r_kind;
  logic [ADDR_WIDTH-1:0] r_cfgAddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_pready;
  logic                  r_pslverr;
  logic                  w_setup;
  logic                  w_done;
  logic                  w_timeout;

  apb_uart_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_decode (
    .i_addr (PADDR),
    .i_write(PWRITE),
    .o_kind (w_decKind)
  );

  assign w_setup = (r_state == IDLE) && PSEL && !PENABLE;
  assign w_done  = (r_state == REQ) && PSEL && ready;

`ifdef APB_UART_BRIDGE_TIMEOUT_EN
  localparam int CntWidth = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntWidth-1:0] r_tmoCnt;

  // Counts cycles spent in REQ; held at zero elsewhere so that every
  // request starts counting from zero on entry.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_tmoCnt <= '0;
    end else if (r_state != REQ) begin
      r_tmoCnt <= '0;
    end else begin
      r_tmoCnt <= r_tmoCnt + 1'b1;
    end
  end

  // A late ready still wins over the timeout in the same cycle.
  assign w_timeout = (r_state == REQ) && PSEL && !ready &&
                     (r_tmoCnt == CntWidth'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Dropping PSEL in REQ is a master abort and returns
  // straight to IDLE without a response.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_setup) begin
          w_nextState = (w_decKind == ILLEGAL) ? RESP : REQ;
        end
      end
      REQ: begin
        if (!PSEL) begin
          w_nextState = IDLE;
        end else if (ready || w_timeout) begin
          w_nextState = RESP;
        end
      end
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Request strobes are decoded from state alone so the core still sees
  // its strobe in the cycle where ready is sampled.
  always_comb begin
    TX_detect           = 1'b0;
    RX_detect           = 1'b0;
    config_write_detect = 1'b0;
    config_read_detect  = 1'b0;
    if (r_state == REQ) begin
      case (r_kind)
        CFG_WR:  config_write_detect = 1'b1;
        CFG_RD:  config_read_detect  = 1'b1;
        TX:      TX_detect           = 1'b1;
        RX:      RX_detect           = 1'b1;
        default: ;
      endcase
    end
  end

  // Setup-phase capture; these values stay put until the next setup so
  // the core can sample them at any point of the request.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_cfgAddr <= '0;
      r_wdata   <= '0;
      r_kind    <= ILLEGAL;
    end else if (w_setup) begin
      r_cfgAddr <= PADDR;
      r_wdata   <= PWDATA;
      r_kind    <= w_decKind;
    end
  end

  // Registered response. PREADY is raised on the edge that enters RESP,
  // which makes it coincide with the single RESP cycle.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else if (w_setup && (w_decKind == ILLEGAL)) begin
      r_prdata  <= '0;
      r_pready  <= 1'b1;
      r_pslverr <= 1'b1;
    end else if (w_done) begin
      r_prdata  <= ((r_kind == CFG_RD) || (r_kind == RX)) ? read_data : '0;
      r_pready  <= 1'b1;
      r_pslverr <= error;
    end else if (w_timeout) begin
      r_prdata  <= '0;
      r_pready  <= 1'b1;
      r_pslverr <= 1'b1;
    end else begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end
  end

  assign PRDATA         = r_prdata;
  assign PREADY         = r_pready;
  assign PSLVERR        = r_pslverr;
  assign config_address = r_cfgAddr;
  assign write_data_in  = r_wdata;

endmodule

// File: tb/tb_apb_uart_bridge.sv
// tb_apb_uart_bridge
// Directed bench for apb_uart_bridge. Each APB transfer is driven on a fixed
// cycle schedule while the bench plays the core (ready after a chosen delay).
// Expected strobes and responses come from a transaction-level model of the
// address map; a negedge process compares them every cycle, and a few
// literal checks pin the model's results.
module tb_apb_uart_bridge;

  localparam int DW = 32;
  localparam int AW = 8;
`ifdef APB_UART_BRIDGE_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic [AW-1:0] config_address;
  logic [DW-1:0] write_data_in;
  logic          TX_detect;
  logic          RX_detect;
  logic          config_write_detect;
  logic          config_read_detect;
  logic [DW-1:0] read_data;
  logic          ready;
  logic          error;

  apb_uart_bridge #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK               (PCLK),
    .PRESET             (PRESET),
    .PSEL               (PSEL),
    .PENABLE            (PENABLE),
    .PWRITE             (PWRITE),
    .PADDR              (PADDR),
    .PWDATA             (PWDATA),
    .PRDATA             (PRDATA),
    .PREADY             (PREADY),
    .PSLVERR            (PSLVERR),
    .config_address     (config_address),
    .write_data_in      (write_data_in),
    .TX_detect          (TX_detect),
    .RX_detect          (RX_detect),
    .config_write_detect(config_write_detect),
    .config_read_detect (config_read_detect),
    .read_data          (read_data),
    .ready              (ready),
    .error              (error)
  );

  // Free-running bus clock, 10 time units per period.
  always #5 PCLK = ~PCLK;

  int            checks = 0;
  int            fails = 0;
  logic          checkEn = 1'b0;
  logic [3:0]    expStrobe = 4'b0;
  logic          expStrobeCare = 1'b1;
  logic          expPready = 1'b0;
  logic          expPslverr = 1'b0;
  logic [DW-1:0] expPrdata = '0;
  logic          expHold = 1'b0;
  logic [AW-1:0] expAddr = '0;
  logic [DW-1:0] expWdata = '0;
  int            strobeCycles = 0;
  logic [DW-1:0] lastPrdata = '0;
  logic          lastPslverr = 1'b0;

  // Strobe vector ordered {TX, RX, config write, config read}.
  logic [3:0] dutStrobe;
  assign dutStrobe = {TX_detect, RX_detect, config_write_detect, config_read_detect};

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Transaction model of the register map: which strobe a legal access
  // raises, or none for an access the bridge must reject.
  function automatic logic [3:0] modelStrobe(input logic [AW-1:0] a, input logic w);
    int unsigned ai;
    ai = a;
    if ((ai % 4 == 0) && (ai <= 12)) return w ? 4'b0010 : 4'b0001;
    if ((ai == 16) && w) return 4'b1000;
    if ((ai == 20) && !w) return 4'b0100;
    return 4'b0000;
  endfunction

  // Per-cycle comparison against the model's expectations.
  always @(negedge PCLK) begin
    if (checkEn && !PRESET) begin
      if (expStrobeCare) checkOutput("strobes", 64'(dutStrobe), 64'(expStrobe));
      checkOutput("PREADY", 64'(PREADY), 64'(expPready));
      if (expPready) begin
        checkOutput("PSLVERR", 64'(PSLVERR), 64'(expPslverr));
        checkOutput("PRDATA", 64'(PRDATA), 64'(expPrdata));
      end
      if (expHold) begin
        checkOutput("config_address", 64'(config_address), 64'(expAddr));
        checkOutput("write_data_in", 64'(write_data_in), 64'(expWdata));
      end
      if (|dutStrobe) strobeCycles++;
      if (PREADY) begin
        lastPrdata  = PRDATA;
        lastPslverr = PSLVERR;
      end
    end
  end

  task automatic nextCycle();
    @(posedge PCLK);
    #1;
  endtask

  task automatic idleCycles(input int n);
    PSEL = 1'b0;
    PENABLE = 1'b0;
    expStrobe = 4'b0;
    expStrobeCare = 1'b1;
    expPready = 1'b0;
    repeat (n) nextCycle();
  endtask

  // One APB transfer. delay is the REQ cycle index in which the core raises
  // ready (0 = first REQ cycle); a negative delay means ready never comes.
  task automatic applyStimulus(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                               input int delay, input logic [DW-1:0] coreData, input logic coreErr);
    logic [3:0] s;
    int reqCycles;
    s = modelStrobe(a, w);
    strobeCycles = 0;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = wd;
    ready = 1'b0; error = 1'b0; read_data = '0;
    expStrobe = 4'b0; expStrobeCare = 1'b1; expPready = 1'b0; expHold = 1'b0;
    nextCycle();
    PENABLE = 1'b1;
    if (s != 4'b0) begin
      expStrobe = s; expHold = 1'b1; expAddr = a; expWdata = wd;
      reqCycles = (delay >= 0) ? delay + 1 : TMO;
      for (int i = 0; i < reqCycles; i++) begin
        ready     = (delay >= 0) && (i == delay);
        read_data = ready ? coreData : '0;
        error     = ready ? coreErr : 1'b0;
        nextCycle();
      end
      ready = 1'b0; read_data = '0; error = 1'b0;
      expStrobe  = 4'b0;
      expPready  = 1'b1;
      expPslverr = (delay >= 0) ? coreErr : 1'b1;
      expPrdata  = ((delay >= 0) && !w) ? coreData : '0;
    end else begin
      expPready = 1'b1; expPslverr = 1'b1; expPrdata = '0;
    end
    nextCycle();
    PSEL = 1'b0; PENABLE = 1'b0; expPready = 1'b0;
  endtask

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; read_data = '0; ready = 1'b0; error = 1'b0;
    #1;
    checkOutput("reset PRDATA", 64'(PRDATA), 64'h0);
    checkOutput("reset PREADY", 64'(PREADY), 64'h0);
    checkOutput("reset PSLVERR", 64'(PSLVERR), 64'h0);
    checkOutput("reset strobes", 64'(dutStrobe), 64'h0);
    checkOutput("reset config_address", 64'(config_address), 64'h0);
    checkOutput("reset write_data_in", 64'(write_data_in), 64'h0);
    nextCycle();
    PRESET = 1'b0;
    checkEn = 1'b1;
    idleCycles(2);

    $display("[TB] config write BAUD");
    applyStimulus(8'h00, 1'b1, 32'h2580, 1, 32'h0, 1'b0);
    checkOutput("BAUD strobe cycles", 64'(strobeCycles), 64'd2);
    checkOutput("BAUD PSLVERR", 64'(lastPslverr), 64'h0);

    $display("[TB] config read FRAME");
    applyStimulus(8'h04, 1'b0, 32'h0, 1, 32'h8, 1'b0);
    checkOutput("FRAME PRDATA", 64'(lastPrdata), 64'h8);

    $display("[TB] TX write with slow core");
    applyStimulus(8'h10, 1'b1, 32'h41, 20, 32'hDEAD, 1'b0);
    checkOutput("TX strobe cycles", 64'(strobeCycles), 64'd21);
    checkOutput("TX PRDATA", 64'(lastPrdata), 64'h0);

    $display("[TB] illegal accesses back-to-back");
    applyStimulus(8'h20, 1'b0, 32'h0, 1, 32'h0, 1'b0);
    checkOutput("unmapped strobe cycles", 64'(strobeCycles), 64'd0);
    applyStimulus(8'h14, 1'b1, 32'h77, 1, 32'h0, 1'b0);
    checkOutput("RXDATA write PSLVERR", 64'(lastPslverr), 64'h1);
    applyStimulus(8'h10, 1'b0, 32'h0, 1, 32'h0, 1'b0);

    $display("[TB] RX read and core error");
    applyStimulus(8'h14, 1'b0, 32'h0, 0, 32'h5A, 1'b0);
    checkOutput("RX PRDATA", 64'(lastPrdata), 64'h5A);
    applyStimulus(8'h08, 1'b1, 32'h3, 2, 32'h0, 1'b0);
    applyStimulus(8'h0C, 1'b0, 32'h0, 1, 32'h2, 1'b1);
    checkOutput("SBITS error PSLVERR", 64'(lastPslverr), 64'h1);
    idleCycles(1);

    $display("[TB] master abort");
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h04; ready = 1'b0;
    expHold = 1'b0; expStrobe = 4'b0;
    nextCycle();
    PENABLE = 1'b1; expStrobe = 4'b0001;
    nextCycle();
    PSEL = 1'b0; PENABLE = 1'b0; expStrobeCare = 1'b0;
    nextCycle();
    idleCycles(2);

    $display("[TB] reset during request");
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h10; PWDATA = 32'h99;
    nextCycle();
    PENABLE = 1'b1; expStrobe = 4'b1000;
    #2;
    PRESET = 1'b1;
    #1;
    checkOutput("mid-reset strobes", 64'(dutStrobe), 64'h0);
    checkOutput("mid-reset PREADY", 64'(PREADY), 64'h0);
    checkOutput("mid-reset write_data_in", 64'(write_data_in), 64'h0);
    PSEL = 1'b0; PENABLE = 1'b0; expStrobe = 4'b0; expHold = 1'b0;
    nextCycle();
    PRESET = 1'b0;
    idleCycles(2);
    applyStimulus(8'h00, 1'b0, 32'h0, 1, 32'h2580, 1'b0);
    checkOutput("post-reset BAUD PRDATA", 64'(lastPrdata), 64'h2580);

`ifdef APB_UART_BRIDGE_TIMEOUT_EN
    $display("[TB] timeout");
    applyStimulus(8'h10, 1'b1, 32'h55, -1, 32'h0, 1'b0);
    checkOutput("timeout strobe cycles", 64'(strobeCycles), 64'd16);
    checkOutput("timeout PSLVERR", 64'(lastPslverr), 64'h1);
    checkOutput("timeout PRDATA", 64'(lastPrdata), 64'h0);
`endif

    idleCycles(3);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
